// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and default width for serial_add
package serial_add_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_add_cell.sv
// rtl/full_add_cell.sv - combinational full adder from two half adders and an OR
module full_add_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s1;
    logic c1;
    logic c2;

    half_add u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
    half_add u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

    assign co = c1 | c2;

endmodule

// File: rtl/half_add.sv
// rtl/half_add.sv - single-bit half adder
module half_add (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add.sv
// rtl/serial_add.sv - bit-serial adder, one full-add cell per cycle, LSB first
module serial_add
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             fa_s;
    logic             fa_co;

    // acc_q holds operand A; each sum bit enters at the MSB as A's bits leave at the LSB,
    // so after WIDTH shifts it holds the complete result.
    full_add_cell u_fa (
        .a  (acc_q[0]),
        .b  (opb_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = a;
                    opb_d   = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d   = {fa_s, acc_q[WIDTH-1:1]};
                opb_d   = {1'b0, opb_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    s_d     = {fa_s, acc_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add.sv
// tb/tb_serial_add.sv - randomized self-checking bench for serial_add
module tb_serial_add;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;

    int n_cmp;
    int n_err;

    serial_add #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts one addition from an IDLE cycle and returns at the negedge where done is seen.
    task automatic run_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rc,
                          input bit scramble, output int lat, output logic [W-1:0] so,
                          output logic co, output bit held);
        logic [W-1:0] prev_s;
        int cnt;
        @(negedge clk);
        prev_s = s;
        held   = 1'b1;
        a = ra; b = rb; cin = rc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!done && cnt < 20) begin
            if (s !== prev_s) held = 1'b0;
            if (scramble) begin
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
            end
            @(negedge clk);
            cnt++;
        end
        lat = done ? cnt : -1;
        so  = s;
        co  = cout;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, cout, s} !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b cout=%b s=%h, required all 0", busy, done, cout, s);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [4] = '{8'h0F, 8'hFF, 8'hFF, 8'h00};
        logic [W-1:0] tb [4] = '{8'h01, 8'h01, 8'hFF, 8'h00};
        logic         tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        logic [W-1:0] so;
        logic co;
        bit held;
        logic [W:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp = {1'b0, ta[i]} + {1'b0, tb[i]} + (W+1)'(tc[i]);
            run_op(ta[i], tb[i], tc[i], 1'b0, lat, so, co, held);
            n_cmp++;
            if (lat != W) begin
                n_err++;
                $display("FAIL directed_latency[%0d]: got %0d edges after start, required %0d", i, lat, W);
            end
            n_cmp++;
            if ({co, so} !== exp) begin
                n_err++;
                $display("FAIL directed_sum[%0d]: cout,s=%b,%h required %b,%h", i, co, so, exp[W], exp[W-1:0]);
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL directed_pulse[%0d]: done=%b busy=%b one cycle after done, required 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_random_scramble;
        logic [W-1:0] ra, rb;
        logic rc;
        logic [W:0] exp;
        int lat;
        logic [W-1:0] so;
        logic co;
        bit held;
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            exp = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
            run_op(ra, rb, rc, 1'b1, lat, so, co, held);
            n_cmp++;
            if (lat != W || {co, so} !== exp || !held) begin
                n_err++;
                $display("FAIL random_op[%0d]: a=%h b=%h cin=%b lat=%0d cout,s=%b,%h held=%0d required lat=%0d %b,%h held=1",
                         i, ra, rb, rc, lat, co, so, held, W, exp[W], exp[W-1:0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit exp_done, exp_busy;
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            exp_done = ((k % (W + 2)) == W);
            exp_busy = ((k % (W + 2)) != W + 1);
            n_cmp++;
            if (done !== exp_done || busy !== exp_busy) begin
                n_err++;
                $display("FAIL b2b_timing[%0d]: done=%b busy=%b required %b %b", k, done, busy, exp_done, exp_busy);
            end
            if (exp_done) begin
                n_cmp++;
                if ({cout, s} !== 9'h046) begin
                    n_err++;
                    $display("FAIL b2b_sum[%0d]: cout,s=%b,%h required 0,46", k, cout, s);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_abort;
        int dones;
        int lat;
        logic [W-1:0] so;
        logic co;
        bit held;
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, cout, s} !== '0) begin
            n_err++;
            $display("FAIL abort_reset: busy=%b done=%b cout=%b s=%h, required all 0", busy, done, cout, s);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL abort_no_done: %0d busy/done cycles after abort, required 0", dones);
        end
        run_op(8'h80, 8'h80, 1'b0, 1'b0, lat, so, co, held);
        n_cmp++;
        if (lat != W || {co, so} !== 9'h100) begin
            n_err++;
            $display("FAIL abort_restart: lat=%0d cout,s=%b,%h required %0d 1,00", lat, co, so, W);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_random_scramble();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
